// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit:
// opcodes, functs, FSM states, datapath select codes and instruction classes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_NOP  = 6'b000000;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_LUI = 3'd3;

  localparam logic [1:0] NPC_SEQ = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_RS  = 2'd3;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

  localparam int C_ADDU = 0;
  localparam int C_SUBU = 1;
  localparam int C_JR   = 2;
  localparam int C_NOP  = 3;
  localparam int C_ORI  = 4;
  localparam int C_LW   = 5;
  localparam int C_SW   = 6;
  localparam int C_BEQ  = 7;
  localparam int C_LUI  = 8;
  localparam int C_JAL  = 9;
  localparam int NCLS   = 10;

  typedef logic [NCLS-1:0] cls_t;

endpackage

// File: rtl/instr_class_dec.sv
// Opcode/funct to one-hot instruction class.
// Encodings outside the supported set raise illegal with cls all zero.
import mips_ctrl_pkg::*;

module instr_class_dec (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output cls_t       cls,
  output logic       illegal
);

  always_comb begin
    cls     = '0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls[C_ADDU] = 1'b1;
          FN_SUBU: cls[C_SUBU] = 1'b1;
          FN_JR:   cls[C_JR]   = 1'b1;
          FN_NOP:  cls[C_NOP]  = 1'b1;
          default: illegal     = 1'b1;
        endcase
      end
      OP_ORI:  cls[C_ORI] = 1'b1;
      OP_LW:   cls[C_LW]  = 1'b1;
      OP_SW:   cls[C_SW]  = 1'b1;
      OP_BEQ:  cls[C_BEQ] = 1'b1;
      OP_LUI:  cls[C_LUI] = 1'b1;
      OP_JAL:  cls[C_JAL] = 1'b1;
      default: illegal    = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing.
// MULTICYCLE_CTRL_PERF_EN adds cycle_cnt/instr_cnt counters.
import mips_ctrl_pkg::*;

module multicycle_ctrl #(
  parameter int RA_IDX = 31,
  parameter int CNT_W  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] npc_sel,
  output logic       rf_we,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       alu_src,
  output logic       ext_op,
  output logic [2:0] alu_op,
  output logic       instr_done,
  output logic       illegal,
  output logic [2:0] state
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  if (RA_IDX < 0 || RA_IDX > 31) begin : g_ra_chk
    $error("RA_IDX must be a 5-bit register index");
  end
  if (CNT_W < 1) begin : g_cnt_chk
    $error("CNT_W must be at least 1");
  end

  state_t st, nx;
  cls_t   cls;
  logic   bad;

  instr_class_dec u_dec (
    .opcode  (opcode),
    .funct   (funct),
    .cls     (cls),
    .illegal (bad)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= S_FETCH;
    else        st <= nx;
  end

  assign state = st;

  // Reset gates every strobe so an aborted instruction leaves no trace.
  always_comb begin
    nx         = st;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    npc_sel    = NPC_SEQ;
    rf_we      = 1'b0;
    reg_dst    = RD_RT;
    wd_sel     = WD_ALU;
    alu_src    = 1'b0;
    ext_op     = 1'b0;
    alu_op     = ALU_ADD;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (reset) begin
      unique case (st)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_we = 1'b1;
            pc_we = 1'b1;
            nx    = S_DECODE;
          end
        end
        S_DECODE: begin
          if (bad) begin
            illegal = 1'b1;
            nx      = S_FETCH;
          end else begin
            unique case (1'b1)
              cls[C_NOP]: begin
                instr_done = 1'b1;
                nx         = S_FETCH;
              end
              cls[C_JAL]: begin
                rf_we      = 1'b1;
                reg_dst    = RD_RA;
                wd_sel     = WD_PC4;
                pc_we      = 1'b1;
                npc_sel    = NPC_J;
                instr_done = 1'b1;
                nx         = S_FETCH;
              end
              default: nx = S_EXEC;
            endcase
          end
        end
        S_EXEC: begin
          unique case (1'b1)
            cls[C_ADDU], cls[C_SUBU]: begin
              alu_op = cls[C_SUBU] ? ALU_SUB : ALU_ADD;
              nx     = S_WB;
            end
            cls[C_ORI]: begin
              alu_src = 1'b1;
              alu_op  = ALU_OR;
              nx      = S_WB;
            end
            cls[C_LUI]: begin
              alu_src = 1'b1;
              alu_op  = ALU_LUI;
              nx      = S_WB;
            end
            cls[C_LW], cls[C_SW]: begin
              ext_op  = 1'b1;
              alu_src = 1'b1;
              nx      = S_MEM;
            end
            cls[C_BEQ]: begin
              alu_op     = ALU_SUB;
              pc_we      = zero;
              npc_sel    = NPC_BR;
              instr_done = 1'b1;
              nx         = S_FETCH;
            end
            cls[C_JR]: begin
              pc_we      = 1'b1;
              npc_sel    = NPC_RS;
              instr_done = 1'b1;
              nx         = S_FETCH;
            end
            default: nx = S_FETCH;
          endcase
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = cls[C_SW];
          if (dmem_ready) begin
            instr_done = cls[C_SW];
            nx         = cls[C_SW] ? S_FETCH : S_WB;
          end
        end
        S_WB: begin
          rf_we      = 1'b1;
          reg_dst    = (cls[C_ADDU] | cls[C_SUBU]) ? RD_RD : RD_RT;
          wd_sel     = cls[C_LW] ? WD_MEM : WD_ALU;
          instr_done = 1'b1;
          nx         = S_FETCH;
        end
        default: nx = S_FETCH;
      endcase
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      instr_cnt <= instr_cnt + CNT_W'(instr_done);
    end
  end
`endif

endmodule
